// File: rtl/irrigation_scheduler.sv
// Tank fill valve with hysteresis and timeout, plus a round-robin irrigation
// scheduler over ZONES soil zones. Every sensor pin is synchronised and debounced first.
module irrigation_scheduler #(
    parameter int ZONES    = 4,
    parameter int DEBOUNCE = 4,
    parameter int RUN_MAX  = 16,
    parameter int FILL_MAX = 32,
    parameter int GAP      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   low,
    input  logic                                   mid,
    input  logic                                   high,
    input  logic [ZONES-1:0]                       us,
    input  logic                                   ua,
    input  logic                                   t,
    input  logic                                   ack,
    output logic                                   watter_supply,
    output logic                                   error,
    output logic                                   alarme,
    output logic [ZONES-1:0]                       asp,
    output logic [ZONES-1:0]                       got,
    output logic [(ZONES>1 ? $clog2(ZONES) : 1)-1:0] zone,
    output logic                                   busy
);
    localparam int ZW   = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int NIN  = ZONES + 5;
    localparam int DCW  = $clog2(DEBOUNCE + 1);
    localparam int FW   = (FILL_MAX > 1) ? $clog2(FILL_MAX) : 1;
    localparam int CMAX = (RUN_MAX > GAP) ? RUN_MAX : GAP;
    localparam int RCW  = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {F_IDLE, F_FILL, F_FAULT} fill_t;
    typedef enum logic [1:0] {I_IDLE, I_RUN, I_GAP} irr_t;

    // Bit layout: us in [ZONES-1:0], then low, mid, high, ua, t; ack on top (sync only).
    logic [NIN:0]                s1_q, s2_q;
    logic [NIN-1:0]              db_q, db_d;
    logic [NIN-1:0][DCW-1:0]     dcnt_q, dcnt_d;

    logic [ZONES-1:0] us_db;
    logic             low_db, mid_db, high_db, ua_db, t_db, ack_s;
    logic             error_c, enable;
    logic             error_q, error_d, alarme_q, alarme_d;

    fill_t            fill_q, fill_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;

    irr_t             irr_q, irr_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic [ZW-1:0]    zone_q, zone_d, ptr_q, ptr_d, pick;
    logic             drip_q, drip_d, found;
    logic [ZONES-1:0] zone_oh;

    function automatic logic [ZW-1:0] wrap(input int a);
        return ZW'((a >= ZONES) ? a - ZONES : a);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {ack, t, ua, high, mid, low, us};
            s2_q <= s1_q;
        end
    end

    // A bit flips only after DEBOUNCE consecutive samples disagreeing with it.
    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            db_d[i]   = db_q[i];
            dcnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DCW'(DEBOUNCE - 1)) db_d[i] = s2_q[i];
                else                                 dcnt_d[i] = dcnt_q[i] + DCW'(1);
            end
        end
    end

    assign us_db   = db_q[ZONES-1:0];
    assign low_db  = db_q[ZONES];
    assign mid_db  = db_q[ZONES+1];
    assign high_db = db_q[ZONES+2];
    assign ua_db   = db_q[ZONES+3];
    assign t_db    = db_q[ZONES+4];
    assign ack_s   = s2_q[NIN];

    assign error_c = (high_db & ~mid_db) | (mid_db & ~low_db);
    assign enable  = low_db & ~error_c;

    always_comb begin
        fill_d = fill_q;
        fcnt_d = fcnt_q;
        case (fill_q)
            F_IDLE: begin
                if (!mid_db && !error_c) begin
                    fill_d = F_FILL;
                    fcnt_d = '0;
                end
            end
            F_FILL: begin
                if (high_db || error_c)                fill_d = F_IDLE;
                else if (fcnt_q == FW'(FILL_MAX - 1)) fill_d = F_FAULT;
                else                                   fcnt_d = fcnt_q + FW'(1);
            end
            F_FAULT: if (ack_s) fill_d = F_IDLE;
            default: fill_d = F_IDLE;
        endcase
        error_d  = error_c;
        alarme_d = error_c | (fill_d == F_FAULT);
    end

    // Round-robin pick: first requesting zone at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int i = 0; i < ZONES; i++) begin
            if (!found && us_db[wrap(int'(ptr_q) + i)]) begin
                found = 1'b1;
                pick  = wrap(int'(ptr_q) + i);
            end
        end
    end

    always_comb begin
        irr_d  = irr_q;
        rcnt_d = rcnt_q;
        zone_d = zone_q;
        ptr_d  = ptr_q;
        drip_d = drip_q;
        case (irr_q)
            I_IDLE: begin
                if (enable && found) begin
                    irr_d  = I_RUN;
                    zone_d = pick;
                    ptr_d  = wrap(int'(pick) + 1);
                    drip_d = t_db | ua_db;
                    rcnt_d = '0;
                end
            end
            I_RUN: begin
                if (!us_db[zone_q] || rcnt_q == RCW'(RUN_MAX - 1) || !enable) begin
                    irr_d  = I_GAP;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            I_GAP: begin
                if (rcnt_q == RCW'(GAP - 1)) irr_d = I_IDLE;
                else                         rcnt_d = rcnt_q + RCW'(1);
            end
            default: irr_d = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q     <= '0;
            dcnt_q   <= '0;
            error_q  <= 1'b0;
            alarme_q <= 1'b0;
            fill_q   <= F_IDLE;
            fcnt_q   <= '0;
            irr_q    <= I_IDLE;
            rcnt_q   <= '0;
            zone_q   <= '0;
            ptr_q    <= '0;
            drip_q   <= 1'b0;
        end else begin
            db_q     <= db_d;
            dcnt_q   <= dcnt_d;
            error_q  <= error_d;
            alarme_q <= alarme_d;
            fill_q   <= fill_d;
            fcnt_q   <= fcnt_d;
            irr_q    <= irr_d;
            rcnt_q   <= rcnt_d;
            zone_q   <= zone_d;
            ptr_q    <= ptr_d;
            drip_q   <= drip_d;
        end
    end

    // Valves decode straight from flops so reset closes them without waiting for a clock.
    assign zone_oh       = ZONES'(1) << zone_q;
    assign asp           = (irr_q == I_RUN && !drip_q) ? zone_oh : '0;
    assign got           = (irr_q == I_RUN &&  drip_q) ? zone_oh : '0;
    assign busy          = (irr_q == I_RUN);
    assign zone          = zone_q;
    assign watter_supply = (fill_q == F_FILL);
    assign error         = error_q;
    assign alarme        = alarme_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Randomised bench for irrigation_scheduler: a cycle-level behavioural model
// predicts outputs into a queue, and a negedge monitor pops and compares.
module tb_irrigation_scheduler;
    localparam int Z   = 4;
    localparam int D   = 4;
    localparam int RM  = 16;
    localparam int FM  = 32;
    localparam int G   = 2;
    localparam int NIN = Z + 5;

    logic clk = 1'b0;
    logic reset;
    logic low, mid, high, ua, t, ack;
    logic [Z-1:0] us;
    logic watter_supply, error, alarme, busy;
    logic [Z-1:0] asp, got;
    logic [1:0] zone;

    always #5 clk = ~clk;

    irrigation_scheduler #(.ZONES(Z), .DEBOUNCE(D), .RUN_MAX(RM), .FILL_MAX(FM), .GAP(G)) dut (
        .clk(clk), .reset(reset), .low(low), .mid(mid), .high(high), .us(us), .ua(ua), .t(t),
        .ack(ack), .watter_supply(watter_supply), .error(error), .alarme(alarme), .asp(asp),
        .got(got), .zone(zone), .busy(busy)
    );

    typedef struct packed {
        logic         ws;
        logic         err;
        logic         alm;
        logic [Z-1:0] asp;
        logic [Z-1:0] got;
        logic [1:0]   zone;
        logic         busy;
    } obs_t;

    obs_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic void chk(input string nm, input obs_t act, input obs_t want);
        compared++;
        if (act !== want) begin
            mismatched++;
            if (mismatched <= 30)
                $display("FAIL %s @%0t: actual ws=%b err=%b alm=%b asp=%b got=%b zone=%0d busy=%b, required ws=%b err=%b alm=%b asp=%b got=%b zone=%0d busy=%b",
                         nm, $time, act.ws, act.err, act.alm, act.asp, act.got, act.zone, act.busy,
                         want.ws, want.err, want.alm, want.asp, want.got, want.zone, want.busy);
        end
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o = {watter_supply, error, alarme, asp, got, zone, busy};
        return o;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [NIN:0]   m_hist[$];      // pin snapshots still travelling through the synchroniser
    logic [NIN-1:0] m_db;
    logic [NIN-1:0] m_last;
    int             m_run[NIN];
    bit             m_filling, m_fault, m_err, m_on, m_drip;
    int             m_age, m_elapsed, m_gap_left, m_zone, m_ptr;

    task automatic m_reset();
        m_hist = {};
        m_hist.push_back('0);
        m_hist.push_back('0);
        m_db = '0; m_last = '0;
        for (int i = 0; i < NIN; i++) m_run[i] = 0;
        m_filling = 0; m_fault = 0; m_err = 0; m_on = 0; m_drip = 0;
        m_age = 0; m_elapsed = 0; m_gap_left = 0; m_zone = 0; m_ptr = 0;
    endtask

    task automatic m_step();
        logic [NIN:0] syn;
        bit lo, mi, hi, en;
        syn = m_hist[0];
        lo = m_db[Z]; mi = m_db[Z+1]; hi = m_db[Z+2];
        m_err = (hi && !mi) || (mi && !lo);
        en = lo && !m_err;

        if (m_fault) begin
            if (syn[NIN]) m_fault = 0;
        end else if (m_filling) begin
            if (hi || m_err) m_filling = 0;
            else if (m_age == FM - 1) begin m_filling = 0; m_fault = 1; end
            else m_age++;
        end else if (!mi && !m_err) begin
            m_filling = 1; m_age = 0;
        end

        if (m_on) begin
            if (!m_db[m_zone] || m_elapsed == RM - 1 || !en) begin m_on = 0; m_gap_left = G; end
            else m_elapsed++;
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (en && (m_db[Z-1:0] != '0)) begin
            for (int i = 0; i < Z; i++) begin
                if (m_db[(m_ptr + i) % Z]) begin
                    m_zone = (m_ptr + i) % Z;
                    break;
                end
            end
            m_ptr = (m_zone + 1) % Z;
            m_drip = m_db[Z+4] || m_db[Z+3];
            m_on = 1; m_elapsed = 0;
        end

        for (int i = 0; i < NIN; i++) begin
            if (syn[i] == m_last[i]) begin
                if (m_run[i] < D) m_run[i]++;
            end else begin
                m_last[i] = syn[i]; m_run[i] = 1;
            end
            if (m_run[i] >= D) m_db[i] = syn[i];
        end
        void'(m_hist.pop_front());
        m_hist.push_back({ack, t, ua, high, mid, low, us});
    endtask

    function automatic obs_t m_out();
        obs_t o;
        logic [Z-1:0] oh;
        oh = '0;
        oh[m_zone] = 1'b1;
        o.ws   = m_filling;
        o.err  = m_err;
        o.alm  = m_err || m_fault;
        o.asp  = (m_on && !m_drip) ? oh : '0;
        o.got  = (m_on &&  m_drip) ? oh : '0;
        o.zone = 2'(m_zone);
        o.busy = m_on;
        return o;
    endfunction

    // ---------------- monitor ----------------
    obs_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("outputs", dut_obs(), mon_e);
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            m_step();
            exp_q.push_back(m_out());
            @(negedge clk);
        end
    endtask

    task automatic set_pins(input bit l, input bit m, input bit h, input logic [Z-1:0] u,
                            input bit a, input bit tt, input bit k);
        low = l; mid = m; high = h; us = u; ua = a; t = tt; ack = k;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        set_pins(0, 0, 0, '0, 0, 0, 0);
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", dut_obs(), '0);
        reset = 1'b0;

        // fill start, mid band hysteresis, stop on high
        set_pins(1, 0, 0, '0, 0, 0, 0); run(20);
        set_pins(1, 1, 0, '0, 0, 0, 0); run(15);
        set_pins(1, 1, 1, '0, 0, 0, 0); run(15);
        // fill timeout, fault latch and ack
        set_pins(1, 0, 0, '0, 0, 0, 0); run(60);
        set_pins(1, 0, 0, '0, 0, 0, 1); run(2);
        set_pins(1, 0, 0, '0, 0, 0, 0); run(20);
        // inconsistent probes abort a run
        set_pins(1, 1, 0, 4'b0001, 0, 0, 0); run(12);
        set_pins(1, 0, 1, 4'b0001, 0, 0, 0); run(20);
        // round robin over zones 0,1,3 in sprinkler mode
        set_pins(1, 1, 0, 4'b1011, 0, 0, 0); run(90);
        set_pins(1, 1, 0, 4'b0000, 0, 0, 0); run(12);
        // drip mode latched for the whole run
        set_pins(1, 1, 0, 4'b0100, 0, 1, 0); run(12);
        set_pins(1, 1, 0, 4'b0100, 0, 0, 0); run(6);
        set_pins(1, 1, 0, 4'b0000, 0, 0, 0); run(12);
        // asynchronous reset in the middle of a run
        set_pins(1, 1, 0, 4'b0010, 0, 0, 0); run(12);
        #2 reset = 1'b1;
        #1 chk("async_reset", dut_obs(), '0);
        m_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_pins(1, 1, 0, 4'b1111, 0, 0, 0); run(40);

        // randomised segments, including short glitches the debounce must reject
        repeat (160) begin
            set_pins(($urandom % 8) != 0, $urandom % 2, ($urandom % 4) == 0, Z'($urandom),
                     $urandom % 2, $urandom % 2, ($urandom % 8) == 0);
            if (($urandom % 5) == 0) run($urandom_range(1, 3));
            else                     run($urandom_range(4, 30));
        end
        set_pins(0, 0, 0, '0, 0, 0, 0);
        run(5);

        repeat (10) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
